dds_sweep_ctrl: RTL
===================

Name: dds_sweep_ctrl

Overview:
- Frequency-sweep sequencer for the DDS sine generator. It produces the phase-accumulator step word (phase_step) that sets output frequency.
- Steps phase_step linearly from a start value to a stop value by a fixed increment. Each value is held for a programmable dwell time.
- Supports single-shot or looped sweeps, with a go/busy/done handshake.
- Sits between the register/config logic and the DDS phase accumulator.

Parameters:
- STEP_N, 32, width of phase-step words (matches the DDS phase accumulator width).
- DWELL_N, 16, width of the dwell counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- cfg_start  in  STEP_N  first phase_step value of the sweep
- cfg_stop  in  STEP_N  final phase_step value (may be above or below cfg_start)
- cfg_incr  in  STEP_N  unsigned increment magnitude per step
- cfg_dwell  in  DWELL_N  each value is held cfg_dwell+1 cycles
- cfg_loop  in  1  1 = restart the sweep continuously after reaching stop
- go  in  1  start request, sampled only in IDLE
- abort  in  1  stop the sweep immediately
- phase_step  out  STEP_N  step word to the DDS accumulator
- step_valid  out  1  1-cycle pulse whenever phase_step takes a new value
- busy  out  1  high while the sweep runs
- done  out  1  1-cycle pulse at normal (non-aborted) sweep completion

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: phase_step=0, step_valid=0, busy=0, done=0, state=IDLE, dwell counter=0.
- States:
  - IDLE: waiting for go.
  - RUN: holding the current value and counting dwell.
- IDLE:
  - phase_step holds its last value.
  - On go=1, at the same edge: latch all cfg_* into shadow registers; phase_step<=cfg_start; step_valid<=1; busy<=1; cnt<=cfg_dwell; dir<=(cfg_stop>=cfg_start); go to RUN.
- RUN, cnt!=0: cnt decrements; no other change.
- RUN, cnt==0, phase_step!=stop:
  - Next value = phase_step ± incr, computed in STEP_N+1 bits.
  - Up direction: if sum>=stop, or sum carried out, load stop. Never wrap.
  - Down direction: if phase_step<incr, or phase_step-incr<=stop, load stop.
  - Load the value, pulse step_valid, cnt<=dwell.
- RUN, cnt==0, phase_step==stop:
  - loop=1: phase_step<=start, pulse step_valid, cnt<=dwell.
  - loop=0: go to IDLE; busy<=0; done<=1 for one cycle; phase_step holds stop.
- Every value, including stop, is held exactly dwell+1 cycles.
- Latency: go to first phase_step update is 1 edge.
- Degenerate configurations:
  - incr==0: the next step loads stop directly (jump).
  - start==stop: one value, then done after dwell+1 cycles.
- cfg_* changes while busy are ignored; shadow copies are used.
- go while busy is ignored.
- abort (any state, priority over go and the step logic):
  - Next edge: state<=IDLE, busy<=0.
  - No done or step_valid pulse.
  - phase_step holds its current value.
- Reset mid-sweep: asynchronous return to reset values.

Optional Feature:
- Macro: DDS_SWEEP_TRI_EN.
- Defined (triangle sweep):
  - On reaching stop (after its dwell), the direction reverses and the sweep steps back toward start using the same clamp rules.
  - Stop is not repeated.
  - Completion means reaching start again and finishing its dwell:
    - loop=0: done pulses.
    - loop=1: direction reverses again, forever.
  - Start is not emitted twice at the turnaround.
- Undefined: sawtooth sweep only, as described in Behaviour; no direction-reversal logic is synthesized.

Test Plan:
- Basic up sweep: start=0x00100000, stop=0x00140000, incr=0x00010000, dwell=2, go at edge E0 -> phase_step = 0x100000@E0, 0x110000@E3, 0x120000@E6, 0x130000@E9, 0x140000@E12; done pulse at E15; busy high E0..E14; 5 step_valid pulses.
- Clamp and down sweep:
  - start=0, stop=0x25000, incr=0x10000, dwell=0 -> 0, 0x10000, 0x20000, 0x25000, then done.
  - start=0x400000, stop=0x100000, incr=0x100000 -> 0x400000, 0x300000, 0x200000, 0x100000, then done.
- No wrap: start=0xFFFF0000, stop=0xFFFFFFFF, incr=0x20000 -> 0xFFFF0000 then 0xFFFFFFFF, never 0x0001xxxx.
  - start=0x30000, stop=0, incr=0x20000 -> 0x30000, 0x10000, 0.
- Loop and abort: loop=1 on the basic sweep -> after 0x140000 is held 3 cycles, 0x100000 reloads and done never pulses. abort at E20 -> busy=0 at E21, phase_step frozen, no done.
- Handshake robustness:
  - go held high throughout the sweep -> a second sweep starts only from IDLE after done.
  - cfg_stop changed mid-sweep -> no effect on the current sweep.
  - rst_n low mid-sweep -> all outputs 0 immediately.
- Triangle (DDS_SWEEP_TRI_EN): basic config, loop=0 -> 0x100000, 0x110000, 0x120000, 0x130000, 0x140000, 0x130000, 0x120000, 0x110000, 0x100000, each held 3 cycles; done pulses once.

Source files
------------

// File: rtl/dds_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : dds_sweep_ctrl_if
// Brief    : Config, handshake and step-word bundle for the DDS sweep sequencer.
// Revision : 1.0
// ============================================================================
interface dds_sweep_ctrl_if #(
    parameter int STEP_N  = 32,
    parameter int DWELL_N = 16
);
    logic [STEP_N-1:0]  cfg_start;
    logic [STEP_N-1:0]  cfg_stop;
    logic [STEP_N-1:0]  cfg_incr;
    logic [DWELL_N-1:0] cfg_dwell;
    logic               cfg_loop;
    logic               go;
    logic               abort;
    logic [STEP_N-1:0]  phase_step;
    logic               step_valid;
    logic               busy;
    logic               done;

    modport master (
        output cfg_start, cfg_stop, cfg_incr, cfg_dwell, cfg_loop, go, abort,
        input  phase_step, step_valid, busy, done
    );

    modport slave (
        input  cfg_start, cfg_stop, cfg_incr, cfg_dwell, cfg_loop, go, abort,
        output phase_step, step_valid, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/dds_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dds_sweep_ctrl
// Brief    : Linear phase-step sweep sequencer with dwell, loop and abort.
//            Define DDS_SWEEP_TRI_EN for triangle (up/down) sweeps.
// Revision : 1.0
// ============================================================================
module dds_sweep_ctrl #(
    parameter int STEP_N  = 32,
    parameter int DWELL_N = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dds_sweep_ctrl_if.slave      bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [STEP_N-1:0]  phase_q, phase_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [DWELL_N-1:0] cnt_q, cnt_d;
    logic               dir_q, dir_d;
    logic [STEP_N-1:0]  start_q, start_d;
    logic [STEP_N-1:0]  stop_q, stop_d;
    logic [STEP_N-1:0]  incr_q, incr_d;
    logic [DWELL_N-1:0] dwell_q, dwell_d;
    logic               loop_q, loop_d;
`ifdef DDS_SWEEP_TRI_EN
    logic               leg_q, leg_d;
`endif

    logic [STEP_N-1:0]  w_target;
    logic               w_up;

    // One clamped step toward tgt; the extra bit catches carry/borrow so we never wrap.
    function automatic logic [STEP_N-1:0] f_next(
        input logic [STEP_N-1:0] cur,
        input logic [STEP_N-1:0] inc,
        input logic [STEP_N-1:0] tgt,
        input logic              up
    );
        logic [STEP_N:0] sum;
        logic [STEP_N:0] diff;
        sum  = {1'b0, cur} + {1'b0, inc};
        diff = {1'b0, cur} - {1'b0, inc};
        if (inc == '0)
            f_next = tgt;
        else if (up)
            f_next = (sum[STEP_N] || (sum[STEP_N-1:0] >= tgt)) ? tgt : sum[STEP_N-1:0];
        else
            f_next = (diff[STEP_N] || (diff[STEP_N-1:0] <= tgt)) ? tgt : diff[STEP_N-1:0];
    endfunction

`ifdef DDS_SWEEP_TRI_EN
    assign w_target = leg_q ? start_q : stop_q;
    assign w_up     = dir_q ^ leg_q;
`else
    assign w_target = stop_q;
    assign w_up     = dir_q;
`endif

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        start_d = start_q;
        stop_d  = stop_q;
        incr_d  = incr_q;
        dwell_d = dwell_q;
        loop_d  = loop_q;
`ifdef DDS_SWEEP_TRI_EN
        leg_d   = leg_q;
`endif
        if (bus.abort) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.go) begin
                        start_d = bus.cfg_start;
                        stop_d  = bus.cfg_stop;
                        incr_d  = bus.cfg_incr;
                        dwell_d = bus.cfg_dwell;
                        loop_d  = bus.cfg_loop;
                        phase_d = bus.cfg_start;
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                        cnt_d   = bus.cfg_dwell;
                        dir_d   = (bus.cfg_stop >= bus.cfg_start);
`ifdef DDS_SWEEP_TRI_EN
                        leg_d   = 1'b0;
`endif
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - DWELL_N'(1);
                    end else if (phase_q != w_target) begin
                        phase_d = f_next(phase_q, incr_q, w_target, w_up);
                        valid_d = 1'b1;
                        cnt_d   = dwell_q;
                    end
`ifdef DDS_SWEEP_TRI_EN
                    // Turnaround steps straight away so the end value is not repeated.
                    else if (!leg_q && (start_q != stop_q)) begin
                        leg_d   = 1'b1;
                        phase_d = f_next(phase_q, incr_q, start_q, ~dir_q);
                        valid_d = 1'b1;
                        cnt_d   = dwell_q;
                    end else if (loop_q) begin
                        leg_d   = 1'b0;
                        phase_d = (start_q == stop_q) ? start_q
                                                      : f_next(phase_q, incr_q, stop_q, dir_q);
                        valid_d = 1'b1;
                        cnt_d   = dwell_q;
                    end
`else
                    else if (loop_q) begin
                        phase_d = start_q;
                        valid_d = 1'b1;
                        cnt_d   = dwell_q;
                    end
`endif
                    else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            start_q <= '0;
            stop_q  <= '0;
            incr_q  <= '0;
            dwell_q <= '0;
            loop_q  <= 1'b0;
`ifdef DDS_SWEEP_TRI_EN
            leg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            incr_q  <= incr_d;
            dwell_q <= dwell_d;
            loop_q  <= loop_d;
`ifdef DDS_SWEEP_TRI_EN
            leg_q   <= leg_d;
`endif
        end
    end

    assign bus.phase_step = phase_q;
    assign bus.step_valid = valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule
`default_nettype wire
